// File: rtl/dispatch_stage.sv
// Registered dispatch slot: holds one decoded instruction, resolves its operands from the CDB,
// allocates a destination tag and issues to the ALU RS, Branch RS or LS buffer.
module dispatch_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int TAG_ROOT_W = 4,
    parameter int NAME_W     = 5,
    parameter int OP_W       = 6,
    parameter int CLASS_W    = 4,
    parameter int NUM_CDB    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NAME_W-1:0]                rd_name,
    input  logic [OP_W-1:0]                  op_code,
    input  logic [CLASS_W-1:0]               op_class,
    input  logic [ADDR_W-1:0]                inst_addr,
    input  logic [DATA_W-1:0]                imm,
    input  logic [DATA_W-1:0]                u_imm,
    input  logic [DATA_W-1:0]                j_imm,
    input  logic [DATA_W-1:0]                s_imm,
    input  logic [DATA_W-1:0]                b_imm,
    input  logic [TAG_ROOT_W:0]              reg_tag_o,
    input  logic [TAG_ROOT_W:0]              reg_tag_t,
    input  logic [DATA_W-1:0]                reg_data_o,
    input  logic [DATA_W-1:0]                reg_data_t,
    input  logic [TAG_ROOT_W-1:0]            alu_free_tag,
    input  logic [TAG_ROOT_W-1:0]            ls_free_tag,
    input  logic                             alu_free_valid,
    input  logic                             ls_free_valid,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB*(TAG_ROOT_W+1)-1:0] cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]        cdb_data,
    output logic                             en_wrt,
    output logic [TAG_ROOT_W:0]              wrt_tag,
    output logic [NAME_W-1:0]                wrt_name,
    output logic                             alu_en,
    input  logic                             alu_ready,
    output logic [OP_W-1:0]                  alu_op,
    output logic [DATA_W-1:0]                alu_operand_o,
    output logic [DATA_W-1:0]                alu_operand_t,
    output logic [TAG_ROOT_W:0]              alu_tag_o,
    output logic [TAG_ROOT_W:0]              alu_tag_t,
    output logic [TAG_ROOT_W:0]              alu_tag_w,
    output logic [NAME_W-1:0]                alu_name_w,
    output logic [ADDR_W-1:0]                alu_addr,
    output logic                             branch_en,
    input  logic                             branch_ready,
    output logic [OP_W-1:0]                  branch_op,
    output logic [DATA_W-1:0]                branch_operand_o,
    output logic [DATA_W-1:0]                branch_operand_t,
    output logic [TAG_ROOT_W:0]              branch_tag_o,
    output logic [TAG_ROOT_W:0]              branch_tag_t,
    output logic [DATA_W-1:0]                branch_imm,
    output logic [ADDR_W-1:0]                branch_addr,
    output logic                             ls_en,
    input  logic                             ls_ready,
    output logic [OP_W-1:0]                  ls_op,
    output logic [DATA_W-1:0]                ls_operand_o,
    output logic [DATA_W-1:0]                ls_operand_t,
    output logic [TAG_ROOT_W:0]              ls_tag_o,
    output logic [TAG_ROOT_W:0]              ls_tag_t,
    output logic [TAG_ROOT_W:0]              ls_tag_w,
    output logic [NAME_W-1:0]                ls_name_w,
    output logic [DATA_W-1:0]                ls_imm,
    output logic                             alloc_alu,
    output logic                             alloc_ls
);
    localparam int TAG_W = TAG_ROOT_W + 1;
    localparam logic [TAG_W-1:0] TAG_FREE = '1;

    localparam logic [CLASS_W-1:0] CLASS_LUI   = CLASS_W'(0);
    localparam logic [CLASS_W-1:0] CLASS_AUIPC = CLASS_W'(1);
    localparam logic [CLASS_W-1:0] CLASS_JAL   = CLASS_W'(2);
    localparam logic [CLASS_W-1:0] CLASS_JALR  = CLASS_W'(3);
    localparam logic [CLASS_W-1:0] CLASS_B     = CLASS_W'(4);
    localparam logic [CLASS_W-1:0] CLASS_LD    = CLASS_W'(5);
    localparam logic [CLASS_W-1:0] CLASS_ST    = CLASS_W'(6);
    localparam logic [CLASS_W-1:0] CLASS_RI    = CLASS_W'(7);
    localparam logic [CLASS_W-1:0] CLASS_RR    = CLASS_W'(8);

    // Lowest-numbered matching CDB port wins: scan downward so it is assigned last.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [DATA_W-1:0]         data,
        input logic [NUM_CDB-1:0]        bvalid,
        input logic [NUM_CDB*TAG_W-1:0]  btag,
        input logic [NUM_CDB*DATA_W-1:0] bdata
    );
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        t = tag;
        d = data;
        if (tag != TAG_FREE) begin
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (bvalid[i] && btag[i*TAG_W +: TAG_W] == tag) begin
                    t = TAG_FREE;
                    d = bdata[i*DATA_W +: DATA_W];
                end
            end
        end
        return {t, d};
    endfunction

    logic                  hold_valid;
    logic [CLASS_W-1:0]    cls_p0;
    logic [OP_W-1:0]       op_p0;
    logic [NAME_W-1:0]     rd_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic [DATA_W-1:0]     opd_o_p0, opd_t_p0, imm_p0;
    logic [TAG_W-1:0]      tag_o_p0, tag_t_p0;

    logic                  in_known;
    logic [TAG_W-1:0]      sel_tag_o, sel_tag_t, cap_tag_o, cap_tag_t, snp_tag_o, snp_tag_t;
    logic [DATA_W-1:0]     sel_opd_o, sel_opd_t, sel_imm, cap_opd_o, cap_opd_t, snp_opd_o, snp_opd_t;
    logic                  is_alu, is_br, is_ls, pool_ok, chan_ready, fire, capture, renames;

    // Operand and immediate selection for the incoming instruction
    always_comb begin
        in_known  = 1'b1;
        sel_tag_o = reg_tag_o;
        sel_opd_o = reg_data_o;
        sel_tag_t = TAG_FREE;
        sel_opd_t = '0;
        sel_imm   = '0;
        case (op_class)
            CLASS_LUI, CLASS_AUIPC: sel_opd_t = u_imm;
            CLASS_JAL: begin
                sel_tag_o = TAG_FREE;
                sel_opd_o = DATA_W'(inst_addr);
                sel_opd_t = j_imm;
            end
            CLASS_JALR, CLASS_RI: sel_opd_t = imm;
            CLASS_RR: begin
                sel_tag_t = reg_tag_t;
                sel_opd_t = reg_data_t;
            end
            CLASS_B: begin
                sel_tag_t = reg_tag_t;
                sel_opd_t = reg_data_t;
                sel_imm   = b_imm;
            end
            CLASS_LD: sel_imm = imm;
            CLASS_ST: begin
                sel_tag_t = reg_tag_t;
                sel_opd_t = reg_data_t;
                sel_imm   = s_imm;
            end
            default: begin
                in_known  = 1'b0;
                sel_tag_o = TAG_FREE;
                sel_opd_o = '0;
            end
        endcase
    end

    assign {cap_tag_o, cap_opd_o} = snoop(sel_tag_o, sel_opd_o, cdb_valid, cdb_tag, cdb_data);
    assign {cap_tag_t, cap_opd_t} = snoop(sel_tag_t, sel_opd_t, cdb_valid, cdb_tag, cdb_data);
    assign {snp_tag_o, snp_opd_o} = snoop(tag_o_p0, opd_o_p0, cdb_valid, cdb_tag, cdb_data);
    assign {snp_tag_t, snp_opd_t} = snoop(tag_t_p0, opd_t_p0, cdb_valid, cdb_tag, cdb_data);

    always_comb begin
        is_alu = 1'b0;
        is_br  = 1'b0;
        is_ls  = 1'b0;
        case (cls_p0)
            CLASS_LUI, CLASS_AUIPC, CLASS_JAL, CLASS_JALR, CLASS_RI, CLASS_RR: is_alu = 1'b1;
            CLASS_B:            is_br = 1'b1;
            CLASS_LD, CLASS_ST: is_ls = 1'b1;
            default: ;
        endcase
    end

    assign chan_ready = (is_alu && alu_ready) || (is_br && branch_ready) || (is_ls && ls_ready);
    assign pool_ok    = is_alu ? alu_free_valid : (is_ls ? ls_free_valid : 1'b1);
    assign fire       = hold_valid && !flush && chan_ready && pool_ok;
    assign in_ready   = !flush && (!hold_valid || fire);
    assign capture    = in_valid && in_ready;
    assign renames    = is_alu || (is_ls && cls_p0 != CLASS_ST);

    assign alu_en    = fire && is_alu;
    assign branch_en = fire && is_br;
    assign ls_en     = fire && is_ls;
    assign alloc_alu = alu_en;
    assign alloc_ls  = ls_en;
    assign alu_tag_w = alu_en ? {1'b0, alu_free_tag} : TAG_FREE;
    assign ls_tag_w  = ls_en  ? {1'b1, ls_free_tag}  : TAG_FREE;
    assign en_wrt    = fire && renames && (rd_p0 != '0);
    assign wrt_tag   = en_wrt ? (is_ls ? ls_tag_w : alu_tag_w) : TAG_FREE;
    assign wrt_name  = rd_p0;

    assign alu_op = op_p0;  assign alu_operand_o = opd_o_p0;  assign alu_operand_t = opd_t_p0;
    assign alu_tag_o = tag_o_p0;  assign alu_tag_t = tag_t_p0;
    assign alu_name_w = rd_p0;  assign alu_addr = addr_p0;
    assign branch_op = op_p0;  assign branch_operand_o = opd_o_p0;  assign branch_operand_t = opd_t_p0;
    assign branch_tag_o = tag_o_p0;  assign branch_tag_t = tag_t_p0;
    assign branch_imm = imm_p0;  assign branch_addr = addr_p0;
    assign ls_op = op_p0;  assign ls_operand_o = opd_o_p0;  assign ls_operand_t = opd_t_p0;
    assign ls_tag_o = tag_o_p0;  assign ls_tag_t = tag_t_p0;
    assign ls_name_w = (cls_p0 == CLASS_ST) ? '0 : rd_p0;
    assign ls_imm = imm_p0;

    // Slot register: capture, or hold with CDB snoop updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            cls_p0     <= '0;
            op_p0      <= '0;
            rd_p0      <= '0;
            addr_p0    <= '0;
            opd_o_p0   <= '0;
            opd_t_p0   <= '0;
            imm_p0     <= '0;
            tag_o_p0   <= TAG_FREE;
            tag_t_p0   <= TAG_FREE;
        end else if (capture) begin
            hold_valid <= in_known;
            cls_p0     <= op_class;
            op_p0      <= op_code;
            rd_p0      <= rd_name;
            addr_p0    <= inst_addr;
            opd_o_p0   <= cap_opd_o;
            opd_t_p0   <= cap_opd_t;
            imm_p0     <= sel_imm;
            tag_o_p0   <= cap_tag_o;
            tag_t_p0   <= cap_tag_t;
        end else begin
            hold_valid <= hold_valid && !fire && !flush;
            opd_o_p0   <= snp_opd_o;
            opd_t_p0   <= snp_opd_t;
            tag_o_p0   <= snp_tag_o;
            tag_t_p0   <= snp_tag_t;
        end
    end
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: per-class vector table plus stall, snoop, stream,
// flush and reset sequences.
module tb_dispatch_stage;
    localparam logic [4:0]  F     = 5'h1F;
    localparam logic [31:0] IMM   = 32'h100;
    localparam logic [31:0] UIMM  = 32'h2000;
    localparam logic [31:0] JIMM  = 32'h30;
    localparam logic [31:0] SIMM  = 32'h44;
    localparam logic [31:0] BIMM  = 32'h55;
    localparam logic [31:0] IADDR = 32'h1000;
    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3, C_B = 4'd4;
    localparam logic [3:0] C_LD = 4'd5, C_ST = 4'd6, C_RI = 4'd7, C_RR = 4'd8;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready;
    logic [4:0] rd_name;
    logic [5:0] op_code;
    logic [3:0] op_class;
    logic [31:0] inst_addr, imm, u_imm, j_imm, s_imm, b_imm;
    logic [4:0] reg_tag_o, reg_tag_t;
    logic [31:0] reg_data_o, reg_data_t;
    logic [3:0] alu_free_tag, ls_free_tag;
    logic alu_free_valid, ls_free_valid;
    logic [1:0] cdb_valid;
    logic [9:0] cdb_tag;
    logic [63:0] cdb_data;
    logic en_wrt;
    logic [4:0] wrt_tag, wrt_name;
    logic alu_en, alu_ready, branch_en, branch_ready, ls_en, ls_ready, alloc_alu, alloc_ls;
    logic [5:0] alu_op, branch_op, ls_op;
    logic [31:0] alu_operand_o, alu_operand_t, branch_operand_o, branch_operand_t;
    logic [31:0] ls_operand_o, ls_operand_t, branch_imm, ls_imm, alu_addr, branch_addr;
    logic [4:0] alu_tag_o, alu_tag_t, alu_tag_w, branch_tag_o, branch_tag_t;
    logic [4:0] ls_tag_o, ls_tag_t, ls_tag_w, alu_name_w, ls_name_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dispatch_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd_name(rd_name), .op_code(op_code), .op_class(op_class), .inst_addr(inst_addr),
        .imm(imm), .u_imm(u_imm), .j_imm(j_imm), .s_imm(s_imm), .b_imm(b_imm),
        .reg_tag_o(reg_tag_o), .reg_tag_t(reg_tag_t), .reg_data_o(reg_data_o), .reg_data_t(reg_data_t),
        .alu_free_tag(alu_free_tag), .ls_free_tag(ls_free_tag),
        .alu_free_valid(alu_free_valid), .ls_free_valid(ls_free_valid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .en_wrt(en_wrt), .wrt_tag(wrt_tag), .wrt_name(wrt_name),
        .alu_en(alu_en), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_operand_o(alu_operand_o), .alu_operand_t(alu_operand_t),
        .alu_tag_o(alu_tag_o), .alu_tag_t(alu_tag_t), .alu_tag_w(alu_tag_w),
        .alu_name_w(alu_name_w), .alu_addr(alu_addr),
        .branch_en(branch_en), .branch_ready(branch_ready), .branch_op(branch_op),
        .branch_operand_o(branch_operand_o), .branch_operand_t(branch_operand_t),
        .branch_tag_o(branch_tag_o), .branch_tag_t(branch_tag_t),
        .branch_imm(branch_imm), .branch_addr(branch_addr),
        .ls_en(ls_en), .ls_ready(ls_ready), .ls_op(ls_op),
        .ls_operand_o(ls_operand_o), .ls_operand_t(ls_operand_t),
        .ls_tag_o(ls_tag_o), .ls_tag_t(ls_tag_t), .ls_tag_w(ls_tag_w),
        .ls_name_w(ls_name_w), .ls_imm(ls_imm),
        .alloc_alu(alloc_alu), .alloc_ls(alloc_ls)
    );

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  t1;
        logic [31:0] d1;
        logic [4:0]  t2;
        logic [31:0] d2;
        int          ch;      // 0 = ALU, 1 = branch, 2 = LS
        logic [31:0] eo;
        logic [31:0] et;
        logic [4:0]  eto;
        logic [4:0]  ett;
        logic        wrt;
        logic [31:0] eimm;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] t1,
                         input logic [31:0] d1, input logic [4:0] t2, input logic [31:0] d2);
        in_valid   = 1'b1;
        op_class   = c;
        op_code    = {2'b01, c};
        rd_name    = rd;
        reg_tag_o  = t1;
        reg_data_o = d1;
        reg_tag_t  = t2;
        reg_data_t = d2;
    endtask

    initial begin
        logic [31:0] o, t, im, ad;
        logic [4:0]  to, tt, tw, nm;
        logic [5:0]  op;
        logic [2:0]  exp_en;
        logic [1:0]  exp_alloc;

        vecs[0] = '{C_RR,    5'd3, 5'h03, 32'h11, F,     32'h22, 0, 32'h11, 32'h22, 5'h03, F,     1'b1, 32'h0};
        vecs[1] = '{C_RI,    5'd4, F,     32'h11, 5'h0A, 32'h22, 0, 32'h11, IMM,    F,     F,     1'b1, 32'h0};
        vecs[2] = '{C_LUI,   5'd1, F,     32'h11, F,     32'h22, 0, 32'h11, UIMM,   F,     F,     1'b1, 32'h0};
        vecs[3] = '{C_AUIPC, 5'd2, 5'h04, 32'h11, F,     32'h22, 0, 32'h11, UIMM,   5'h04, F,     1'b1, 32'h0};
        vecs[4] = '{C_JAL,   5'd1, 5'h07, 32'h11, 5'h08, 32'h22, 0, IADDR,  JIMM,   F,     F,     1'b1, 32'h0};
        vecs[5] = '{C_JALR,  5'd6, F,     32'h33, F,     32'h22, 0, 32'h33, IMM,    F,     F,     1'b1, 32'h0};
        vecs[6] = '{C_B,     5'd9, F,     32'h11, 5'h09, 32'h22, 1, 32'h11, 32'h22, F,     5'h09, 1'b0, BIMM};
        vecs[7] = '{C_LD,    5'd7, 5'h0B, 32'h11, 5'h0C, 32'h22, 2, 32'h11, 32'h0,  5'h0B, F,     1'b1, IMM};
        vecs[8] = '{C_ST,    5'd7, F,     32'h11, 5'h0C, 32'h22, 2, 32'h11, 32'h22, F,     5'h0C, 1'b0, SIMM};
        vecs[9] = '{C_RR,    5'd0, F,     32'h5,  F,     32'h6,  0, 32'h5,  32'h6,  F,     F,     1'b0, 32'h0};

        rst = 1'b0; flush = 1'b0;
        inst_addr = IADDR; imm = IMM; u_imm = UIMM; j_imm = JIMM; s_imm = SIMM; b_imm = BIMM;
        alu_free_tag = 4'd5; ls_free_tag = 4'd2; alu_free_valid = 1'b1; ls_free_valid = 1'b1;
        alu_ready = 1'b1; branch_ready = 1'b1; ls_ready = 1'b1;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        drive(C_RR, 5'd3, 5'h03, 32'h11, F, 32'h22);

        // Reset with an instruction offered
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_en", {alu_en, branch_en, ls_en, en_wrt}, 4'b0);
        chk("rst_alloc", {alloc_alu, alloc_ls}, 2'b0);
        chk("rst_tags", {alu_tag_o, alu_tag_t, alu_tag_w, ls_tag_w, wrt_tag}, {F, F, F, F, F});
        chk("rst_payload", alu_operand_o, 32'h0);
        in_valid = 1'b0;
        tick();

        // One instruction per class, all channels ready
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].cls, vecs[i].rd, vecs[i].t1, vecs[i].d1, vecs[i].t2, vecs[i].d2);
            tick();
            in_valid = 1'b0;
            #1;
            o = '0; t = '0; to = '0; tt = '0; tw = '0; op = '0; ad = '0; nm = '0; im = '0;
            exp_en = 3'b000; exp_alloc = 2'b00;
            case (vecs[i].ch)
                0: begin
                    o = alu_operand_o; t = alu_operand_t; to = alu_tag_o; tt = alu_tag_t;
                    tw = alu_tag_w; op = alu_op; ad = alu_addr; nm = alu_name_w;
                    exp_en = 3'b100; exp_alloc = 2'b10;
                end
                1: begin
                    o = branch_operand_o; t = branch_operand_t; to = branch_tag_o; tt = branch_tag_t;
                    op = branch_op; ad = branch_addr; im = branch_imm;
                    exp_en = 3'b010;
                end
                default: begin
                    o = ls_operand_o; t = ls_operand_t; to = ls_tag_o; tt = ls_tag_t;
                    tw = ls_tag_w; op = ls_op; nm = ls_name_w; im = ls_imm;
                    exp_en = 3'b001; exp_alloc = 2'b01;
                end
            endcase
            chk($sformatf("v%0d_en", i), {alu_en, branch_en, ls_en}, exp_en);
            chk($sformatf("v%0d_alloc", i), {alloc_alu, alloc_ls}, exp_alloc);
            chk($sformatf("v%0d_opd_o", i), o, vecs[i].eo);
            chk($sformatf("v%0d_opd_t", i), t, vecs[i].et);
            chk($sformatf("v%0d_tag_o", i), to, vecs[i].eto);
            chk($sformatf("v%0d_tag_t", i), tt, vecs[i].ett);
            chk($sformatf("v%0d_op", i), op, {2'b01, vecs[i].cls});
            chk($sformatf("v%0d_en_wrt", i), en_wrt, vecs[i].wrt);
            if (vecs[i].wrt) chk($sformatf("v%0d_wrt_name", i), wrt_name, vecs[i].rd);
            if (vecs[i].ch == 0) begin
                chk($sformatf("v%0d_tag_w", i), tw, 5'h05);
                chk($sformatf("v%0d_name_w", i), nm, vecs[i].rd);
            end
            if (vecs[i].ch == 2) begin
                chk($sformatf("v%0d_tag_w", i), tw, 5'h12);
                chk($sformatf("v%0d_name_w", i), nm, vecs[i].wrt ? vecs[i].rd : 5'd0);
            end
            if (vecs[i].ch != 0) chk($sformatf("v%0d_imm", i), im, vecs[i].eimm);
            if (vecs[i].ch != 2) chk($sformatf("v%0d_addr", i), ad, IADDR);
            tick();
        end

        // LD stalled on the LS free-tag supply
        ls_free_valid = 1'b0;
        drive(C_LD, 5'd7, F, 32'h77, F, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ldstall%0d_ls_en", k), ls_en, 1'b0);
            chk($sformatf("ldstall%0d_in_ready", k), in_ready, 1'b0);
            chk($sformatf("ldstall%0d_alloc", k), alloc_ls, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        ls_free_valid = 1'b1; ls_free_tag = 4'd2;
        #1;
        chk("ldgo_ls_en", ls_en, 1'b1);
        chk("ldgo_tag_w", ls_tag_w, 5'h12);
        chk("ldgo_imm", ls_imm, IMM);
        chk("ldgo_opd_o", ls_operand_o, 32'h77);
        chk("ldgo_wrt_tag", wrt_tag, 5'h12);
        tick();
        chk("ldgo_done", ls_en, 1'b0);

        // CDB snoop at capture (both ports match, port 0 wins) and while held
        alu_ready = 1'b0;
        drive(C_RR, 5'd5, 5'h06, 32'h0, 5'h12, 32'h0);
        cdb_valid = 2'b11; cdb_tag = {5'h06, 5'h06}; cdb_data = {32'hBBBB, 32'hAAAA};
        tick();
        in_valid = 1'b0;
        cdb_valid = 2'b10; cdb_tag = {5'h12, 5'h06}; cdb_data = {32'hDEAD, 32'h1111};
        #1;
        chk("snp_cap_opd_o", alu_operand_o, 32'hAAAA);
        chk("snp_cap_tag_o", alu_tag_o, F);
        chk("snp_cap_tag_t", alu_tag_t, 5'h12);
        chk("snp_cap_alu_en", alu_en, 1'b0);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("snp_hold_opd_t", alu_operand_t, 32'hDEAD);
        chk("snp_hold_tag_t", alu_tag_t, F);
        chk("snp_hold_opd_o", alu_operand_o, 32'hAAAA);
        alu_ready = 1'b1;
        #1;
        chk("snp_release_en", alu_en, 1'b1);
        tick();

        // Back-to-back stream of four RI instructions
        for (int i = 0; i < 5; i++) begin
            alu_free_tag = 4'(i);
            if (i < 4) drive(C_RI, 5'(i + 1), F, 32'h40 + 32'(i), F, 32'h0);
            else in_valid = 1'b0;
            #1;
            if (i > 0) begin
                chk($sformatf("strm%0d_en", i), alu_en, 1'b1);
                chk($sformatf("strm%0d_opd_o", i), alu_operand_o, 32'h40 + 32'(i - 1));
                chk($sformatf("strm%0d_tag_w", i), alu_tag_w, {1'b0, 4'(i)});
                chk($sformatf("strm%0d_in_ready", i), in_ready, 1'b1);
            end
            tick();
        end
        chk("strm_end_en", alu_en, 1'b0);

        // Flush of a stalled branch
        branch_ready = 1'b0;
        drive(C_B, 5'd0, F, 32'h1, F, 32'h2);
        tick();
        in_valid = 1'b0;
        #1;
        chk("fl_held_en", branch_en, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_en", branch_en, 1'b0);
        chk("fl_in_ready", in_ready, 1'b0);
        chk("fl_alloc", {alloc_alu, alloc_ls}, 2'b00);
        tick();
        flush = 1'b0; branch_ready = 1'b1;
        #1;
        chk("fl_after_en", branch_en, 1'b0);
        chk("fl_after_in_ready", in_ready, 1'b1);

        // Reset while an LD is stalled
        ls_free_valid = 1'b0;
        drive(C_LD, 5'd8, F, 32'h9, F, 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("rstm_held_en", ls_en, 1'b0);
        rst = 1'b0;
        #1;
        ls_free_valid = 1'b1;
        #1;
        chk("rstm_en", ls_en, 1'b0);
        chk("rstm_alloc", alloc_ls, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstm_after_en", {ls_en, alloc_ls}, 2'b00);
        chk("rstm_in_ready", in_ready, 1'b1);

        // Unknown class is accepted and never issues
        drive(4'hF, 5'd3, F, 32'h1, F, 32'h2);
        tick();
        in_valid = 1'b0;
        #1;
        chk("unk_en", {alu_en, branch_en, ls_en, en_wrt}, 4'b0);
        chk("unk_in_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Registered, stallable successor of the combinational dispatcher. Sits between decoder/regfile and the ALU RS, Branch RS and LS buffer.
- Holds one decoded instruction in a dispatch slot and allocates a destination tag from the ALU or LS free-tag supply.
- Snoops NUM_CDB result broadcasts so held operands resolve while the slot is stalled.
- Issues to exactly one channel per fire, with valid/ready handshakes on the input side and on every output channel.

Parameters:
DATA_W, 32, data/immediate width
ADDR_W, 32, instruction address width
TAG_ROOT_W, 4, free-tag index width; full tag width is TAG_ROOT_W+1 (MSB is the prefix: 1=LS, 0=ALU)
NAME_W, 5, architectural register name width
OP_W, 6, opcode width
CLASS_W, 4, op-class width; values are the team's ClassLUI..ClassRR codes
NUM_CDB, 2, number of result broadcast ports
TAG_FREE, all-ones, "operand ready" tag value

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
flush  in  1  misprediction flush; drops the slot
in_valid  in  1  decoded instruction valid
in_ready  out  1  slot can accept this cycle
rd_name, op_code, op_class, inst_addr  in  NAME_W/OP_W/CLASS_W/ADDR_W  decoded fields
imm, u_imm, j_imm, s_imm, b_imm  in  DATA_W each  immediates
reg_tag_o, reg_tag_t  in  TAG_ROOT_W+1 each  regfile rename tags (rs1/rs2)
reg_data_o, reg_data_t  in  DATA_W each  regfile values
alu_free_tag, ls_free_tag  in  TAG_ROOT_W each  next free root indices
alu_free_valid, ls_free_valid  in  1 each  free root available
cdb_valid  in  NUM_CDB  broadcast valid
cdb_tag  in  NUM_CDB*(TAG_ROOT_W+1)  flattened broadcast tags
cdb_data  in  NUM_CDB*DATA_W  flattened broadcast data
en_wrt, wrt_tag, wrt_name  out  1/TAG_W/NAME_W  rename write to regfile
alu_en, alu_ready  out/in  1 each  ALU RS handshake
alu_op, alu_operand_o/t, alu_tag_o/t/w, alu_name_w, alu_addr  out  payload
branch_en, branch_ready  out/in  1 each  Branch RS handshake
branch_op, branch_operand_o/t, branch_tag_o/t, branch_imm, branch_addr  out  payload
ls_en, ls_ready  out/in  1 each  LS buffer handshake
ls_op, ls_operand_o/t, ls_tag_o/t/w, ls_name_w, ls_imm  out  payload
alloc_alu, alloc_ls  out  1 each  free-tag consumed pulse

Behaviour:
- Slot state: EMPTY / HELD (hold_valid). Reset (rst=0, async): slot EMPTY, held payload zero, tags = TAG_FREE.
- All *_en, en_wrt and alloc_* reset to 0. Payload outputs reset to 0; tag outputs reset to TAG_FREE.
- Capture: in_valid && in_ready loads the slot.
- Operand/immediate selection per class:
  - LUI/AUIPC: rs1 + u_imm.
  - JAL: inst_addr + j_imm, both tags TAG_FREE.
  - JALR/RI: rs1 + imm.
  - RR: rs1 + rs2.
  - B: rs1, rs2, b_imm.
  - LD: rs1 + imm.
  - ST: rs1, rs2, s_imm.
  - Unused tag = TAG_FREE; unknown class = NOP and never fires.
- CDB snoop: every cycle, for each slot operand with tag != TAG_FREE, a matching cdb_valid[i] && cdb_tag[i] writes cdb_data[i] and sets the tag to TAG_FREE.
- The snoop also applies to the incoming reg_tag_*/reg_data_* in the capture cycle. If several CDB ports match, the lowest index wins.
- Destination pool: LS for LD/ST, ALU for LUI/AUIPC/JAL/JALR/RI/RR, none for B.
- Fire condition: hold_valid && !flush && channel_ready && (pool free_valid, or no pool needed).
- Fire outputs are combinational from the slot and stable while HELD:
  - channel *_en = 1.
  - *_tag_w = {prefix, free_tag}.
  - alloc_* pulses.
  - en_wrt = 1 with wrt_name = rd_name for all classes except B and ST.
  - ST takes an LS tag (ls_tag_w) but does not rename; ls_name_w = 0.
- rd_name = 0 (x0): still fires and consumes a tag; en_wrt = 0.
- in_ready = !hold_valid || fire. Back-to-back: fire and capture in the same cycle gives throughput of 1 instruction/cycle.
- Stall: free_valid = 0 or channel not ready holds the slot with payload unchanged except snoop updates. *_en = 0 during stall.
- Flush: slot EMPTY next edge; no fire that cycle; in_ready = 0 that cycle.
- Reset mid-stall discards the slot; no alloc pulse is emitted.

Test Plan:
- Reset: rst=0 with in_valid=1 → in_ready=1 after release; all *_en=0; tags=TAG_FREE.
- RR, rs1 tag 0x03 pending, alu_free_tag=5 → next cycle alu_en=1, alu_tag_w=0x05, en_wrt=1, alloc_alu=1.
- LD with ls_free_valid=0 for 3 cycles → slot held, in_ready=0, ls_en=0. Then ls_free_valid=1, ls_free_tag=2 → ls_tag_w=0x12, ls_imm=imm.
- Held RR with rs2 tag 0x12: cdb_valid=2'b10, cdb_tag[1]=0x12, data 0xDEAD → next cycle alu_operand_t=0xDEAD, alu_tag_t=TAG_FREE.
- Stream of 4 RI with alu_ready=1 → 4 alu_en pulses in 4 consecutive cycles, tags follow alu_free_tag.
- BEQ held with branch_ready=0, flush=1 → slot empty; branch_en never asserted; no alloc pulse.
